// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the CPU run/step controller.
// State encoding, halt causes and the datapath PC width.
package cpu_ctrl_pkg;

    localparam int PC_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        STEP,
        HALT
    } state_t;

    localparam logic [2:0] CAUSE_NONE  = 3'd0;
    localparam logic [2:0] CAUSE_STOP  = 3'd1;
    localparam logic [2:0] CAUSE_BKPT  = 3'd2;
    localparam logic [2:0] CAUSE_END   = 3'd3;
    localparam logic [2:0] CAUSE_LIMIT = 3'd4;
    localparam logic [2:0] CAUSE_STEP  = 3'd5;

endpackage

// File: rtl/cpu_run_ctrl_run_cnt.sv
// Saturating retired-instruction counter with clear and limit flag.
module run_cnt #(
    parameter int CNT_W = 8,
    parameter int MAX   = 200
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             at_max
);

    localparam logic [CNT_W-1:0] LIM = CNT_W'(MAX);

    assign at_max = (count == LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !at_max) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step controller for the 4-bit CPU datapath.
// Define CPU_RUN_CTRL_BKPT_EN to enable the PC breakpoint comparator.
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int              CNT_W     = 8,
    parameter int              MAX_INSTR = 200,
    parameter logic [PC_W-1:0] END_PC    = 4'hF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cont,
    input  logic             step,
    input  logic             stop,
    input  logic [PC_W-1:0]  start_pc,
    input  logic [PC_W-1:0]  pc_curr,
    input  logic             bp_valid,
    input  logic [PC_W-1:0]  bp_addr,
    output logic             set_pc,
    output logic [PC_W-1:0]  pc_init,
    output logic             dp_en,
    output logic             wr_inhibit,
    output logic             busy,
    output logic             halted,
    output logic [2:0]       halt_cause,
    output logic [CNT_W-1:0] instr_count
);

    state_t state;
    state_t nxt;

    logic       first;
    logic       at_max;
    logic       hit_bp;
    logic       hit_end;
    logic       cmd_ok;
    logic       go_start;
    logic       go_cont;
    logic       go_step;
    logic [2:0] run_cause;
    logic [2:0] step_cause;

    assign cmd_ok   = (state == IDLE) || (state == HALT);
    assign go_start = cmd_ok && start;
    assign go_cont  = cmd_ok && !start && cont;
    assign go_step  = cmd_ok && !start && !cont && step;
    assign hit_end  = (pc_curr == END_PC);

`ifdef CPU_RUN_CTRL_BKPT_EN
    assign hit_bp = bp_valid && (pc_curr == bp_addr) && !first;
`else
    logic bp_unused;
    assign bp_unused = ^{bp_valid, bp_addr, first};
    assign hit_bp    = 1'b0;
`endif

    always_comb begin
        run_cause = CAUSE_NONE;
        if (stop) begin
            run_cause = CAUSE_STOP;
        end else if (hit_bp) begin
            run_cause = CAUSE_BKPT;
        end else if (at_max) begin
            run_cause = CAUSE_LIMIT;
        end else if (hit_end) begin
            run_cause = CAUSE_END;
        end
    end

    // A step at the limit retires nothing and reports LIMIT.
    always_comb begin
        step_cause = CAUSE_STEP;
        if (at_max) begin
            step_cause = CAUSE_LIMIT;
        end else if (hit_end) begin
            step_cause = CAUSE_END;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE, HALT: begin
                if (go_start) begin
                    nxt = LOAD;
                end else if (go_cont) begin
                    nxt = RUN;
                end else if (go_step) begin
                    nxt = STEP;
                end
            end
            LOAD: nxt = RUN;
            RUN: begin
                if (run_cause != CAUSE_NONE) begin
                    nxt = HALT;
                end
            end
            STEP:    nxt = HALT;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        set_pc     = 1'b0;
        dp_en      = 1'b0;
        wr_inhibit = 1'b0;
        busy       = 1'b0;
        halted     = 1'b0;
        unique case (state)
            LOAD: begin
                set_pc     = 1'b1;
                dp_en      = 1'b1;
                wr_inhibit = 1'b1;
                busy       = 1'b1;
            end
            RUN: begin
                busy  = 1'b1;
                dp_en = (run_cause == CAUSE_NONE) ||
                        (run_cause == CAUSE_END);
            end
            STEP: begin
                busy  = 1'b1;
                dp_en = !at_max;
            end
            HALT:    halted = 1'b1;
            default: ;
        endcase
    end

    // First-cycle flag: set on every entry into RUN, clear after one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first <= 1'b0;
        end else begin
            first <= (nxt == RUN) && (state != RUN);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt_cause <= CAUSE_NONE;
        end else if (go_start || go_cont || go_step) begin
            halt_cause <= CAUSE_NONE;
        end else if (state == RUN && run_cause != CAUSE_NONE) begin
            halt_cause <= run_cause;
        end else if (state == STEP) begin
            halt_cause <= step_cause;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_init <= '0;
        end else if (go_start) begin
            pc_init <= start_pc;
        end
    end

    run_cnt #(
        .CNT_W (CNT_W),
        .MAX   (MAX_INSTR)
    ) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (go_start),
        .en     (dp_en && !wr_inhibit),
        .count  (instr_count),
        .at_max (at_max)
    );

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with a behavioural datapath PC.
module tb_cpu_run_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       cont = 1'b0;
    logic       step = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] start_pc = 4'd0;
    logic [3:0] pc_curr;
    logic       bp_valid = 1'b0;
    logic [3:0] bp_addr = 4'd0;
    logic       set_pc;
    logic [3:0] pc_init;
    logic       dp_en;
    logic       wr_inhibit;
    logic       busy;
    logic       halted;
    logic [2:0] halt_cause;
    logic [7:0] instr_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_run_ctrl #(
        .CNT_W     (8),
        .MAX_INSTR (6),
        .END_PC    (4'h5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cont        (cont),
        .step        (step),
        .stop        (stop),
        .start_pc    (start_pc),
        .pc_curr     (pc_curr),
        .bp_valid    (bp_valid),
        .bp_addr     (bp_addr),
        .set_pc      (set_pc),
        .pc_init     (pc_init),
        .dp_en       (dp_en),
        .wr_inhibit  (wr_inhibit),
        .busy        (busy),
        .halted      (halted),
        .halt_cause  (halt_cause),
        .instr_count (instr_count)
    );

    // Datapath PC: load on set_pc, otherwise advance when enabled.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_curr <= 4'd0;
        end else if (dp_en) begin
            pc_curr <= set_pc ? pc_init : pc_curr + 4'd1;
        end
    end

    typedef struct {
        logic       st;
        logic       co;
        logic       sp;
        logic       so;
        logic [3:0] spc;
        logic       e_set;
        logic       e_dp;
        logic       e_wr;
        logic       e_busy;
        logic       e_halt;
        logic [2:0] e_cause;
        logic [7:0] e_cnt;
        logic [3:0] e_pinit;
    } vec_t;

    vec_t vt[21];

    function automatic vec_t mk(
        input logic st, input logic co, input logic sp,
        input logic so, input logic [3:0] spc,
        input logic e_set, input logic e_dp, input logic e_wr,
        input logic e_busy, input logic e_halt,
        input logic [2:0] e_cause, input logic [7:0] e_cnt,
        input logic [3:0] e_pinit);
        vec_t v;
        v.st = st; v.co = co; v.sp = sp; v.so = so; v.spc = spc;
        v.e_set = e_set; v.e_dp = e_dp; v.e_wr = e_wr;
        v.e_busy = e_busy; v.e_halt = e_halt;
        v.e_cause = e_cause; v.e_cnt = e_cnt; v.e_pinit = e_pinit;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_halt(input string nm, input int budget);
        int n;
        n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({nm, "_halt_timeout"}, int'(halted), 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0; cont = 1'b0; step = 1'b0; stop = 1'b0;
        bp_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // cols: start cont step stop spc | set dp wr busy halt cause cnt pinit
        vt[0]  = mk(0,0,0,0,0, 0,0,0,0,0,0,0,0);
        vt[1]  = mk(1,0,0,0,3, 0,0,0,0,0,0,0,0);
        vt[2]  = mk(0,0,0,0,0, 1,1,1,1,0,0,0,3);
        vt[3]  = mk(0,0,0,0,0, 0,1,0,1,0,0,0,3);
        vt[4]  = mk(0,0,0,0,0, 0,1,0,1,0,0,1,3);
        vt[5]  = mk(0,0,0,0,0, 0,1,0,1,0,0,2,3);
        vt[6]  = mk(0,0,0,0,0, 0,0,0,0,1,3,3,3);
        vt[7]  = mk(0,0,1,0,0, 0,0,0,0,1,3,3,3);
        vt[8]  = mk(0,0,0,0,0, 0,1,0,1,0,0,3,3);
        vt[9]  = mk(0,0,1,1,0, 0,0,0,0,1,5,4,3);
        vt[10] = mk(0,0,0,1,0, 0,1,0,1,0,0,4,3);
        vt[11] = mk(0,1,0,0,0, 0,0,0,0,1,5,5,3);
        vt[12] = mk(0,0,0,0,0, 0,1,0,1,0,0,5,3);
        vt[13] = mk(0,0,0,0,0, 0,0,0,1,0,0,6,3);
        vt[14] = mk(0,0,1,0,0, 0,0,0,0,1,4,6,3);
        vt[15] = mk(0,0,0,0,0, 0,0,0,1,0,0,6,3);
        vt[16] = mk(1,1,1,0,4, 0,0,0,0,1,4,6,3);
        vt[17] = mk(0,0,0,0,0, 1,1,1,1,0,0,0,4);
        vt[18] = mk(1,0,0,0,9, 0,1,0,1,0,0,0,4);
        vt[19] = mk(0,0,0,0,0, 0,1,0,1,0,0,1,4);
        vt[20] = mk(0,0,0,0,0, 0,0,0,0,1,3,2,4);

        do_reset();
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            start = vt[i].st; cont = vt[i].co;
            step = vt[i].sp; stop = vt[i].so;
            start_pc = vt[i].spc;
            #1;
            chk($sformatf("v%0d_set_pc", i), int'(set_pc), int'(vt[i].e_set));
            chk($sformatf("v%0d_dp_en", i), int'(dp_en), int'(vt[i].e_dp));
            chk($sformatf("v%0d_wr_inh", i), int'(wr_inhibit), int'(vt[i].e_wr));
            chk($sformatf("v%0d_busy", i), int'(busy), int'(vt[i].e_busy));
            chk($sformatf("v%0d_halted", i), int'(halted), int'(vt[i].e_halt));
            chk($sformatf("v%0d_cause", i), int'(halt_cause), int'(vt[i].e_cause));
            chk($sformatf("v%0d_count", i), int'(instr_count), int'(vt[i].e_cnt));
            chk($sformatf("v%0d_pc_init", i), int'(pc_init), int'(vt[i].e_pinit));
        end
        start = 1'b0; cont = 1'b0; step = 1'b0; stop = 1'b0;

        // Breakpoint at PC 2 from start_pc 0.
        @(negedge clk);
        bp_valid = 1'b1; bp_addr = 4'd2;
        start = 1'b1; start_pc = 4'd0;
        @(negedge clk);
        start = 1'b0;
        #1;
        wait_halt("bp_run", 30);
`ifdef CPU_RUN_CTRL_BKPT_EN
        chk("bp_pc", int'(pc_curr), 2);
        chk("bp_cause", int'(halt_cause), 2);
        chk("bp_count", int'(instr_count), 2);
        @(negedge clk);
        cont = 1'b1;
        @(negedge clk);
        cont = 1'b0;
        #1;
        chk("bp_cont_dp_en", int'(dp_en), 1);
        wait_halt("bp_cont", 30);
        chk("bp_cont_cause", int'(halt_cause), 3);
        chk("bp_cont_count", int'(instr_count), 6);
        chk("bp_cont_pc", int'(pc_curr), 6);
`else
        chk("nobp_pc", int'(pc_curr), 6);
        chk("nobp_cause", int'(halt_cause), 3);
        chk("nobp_count", int'(instr_count), 6);
`endif

        // Stop coincident with the breakpoint PC.
        @(negedge clk);
        start = 1'b1; start_pc = 4'd0;
        @(negedge clk);
        start = 1'b0;
        #1;
        for (int n = 0; n < 20; n++) begin
            if (busy && !set_pc && pc_curr == 4'd2) break;
            @(negedge clk);
            #1;
        end
        chk("stop_reach_pc2", int'(busy && !set_pc && pc_curr == 4'd2), 1);
        stop = 1'b1;
        #1;
        chk("stop_dp_en", int'(dp_en), 0);
        @(negedge clk);
        stop = 1'b0;
        #1;
        chk("stop_halted", int'(halted), 1);
        chk("stop_cause", int'(halt_cause), 1);
        chk("stop_count", int'(instr_count), 2);
        bp_valid = 1'b0;

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        start = 1'b1; start_pc = 4'd0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_dp_en", int'(dp_en), 0);
        chk("rst_set_pc", int'(set_pc), 0);
        chk("rst_count", int'(instr_count), 0);
        chk("rst_pc_init", int'(pc_init), 0);
        chk("rst_halted", int'(halted), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b1; start_pc = 4'd7;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("rst_restart_set_pc", int'(set_pc), 1);
        chk("rst_restart_pc_init", int'(pc_init), 7);

        // Three single steps from IDLE.
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            #1;
            chk($sformatf("step%0d_dp_en", k), int'(dp_en), 1);
            chk($sformatf("step%0d_busy", k), int'(busy), 1);
            @(negedge clk);
            #1;
            chk($sformatf("step%0d_halted", k), int'(halted), 1);
            chk($sformatf("step%0d_cause", k), int'(halt_cause), 5);
            chk($sformatf("step%0d_count", k), int'(instr_count), k);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
